// File: rtl/imem_ctrl.sv
// ---------------------------------------------------------------------------
// imem_ctrl
//
// Instruction memory controller. It sits directly upstream of the fetch
// stage.
// - It accepts line reads and byte-masked writes on a valid/ready request
//   port.
// - It issues each accepted request to a synchronous SRAM with a fixed read
//   latency of MEM_LAT cycles.
// - It returns whole 16-byte lines, in request order, through a response
//   FIFO that is protected by credits.
// - Flush discards every read that is in flight or buffered.
//
// Ports
//   clk          clock
//   reset        synchronous reset, active low
//   flush        discard all outstanding and buffered reads
//   req_valid    request valid
//   req_ready    request accepted when req_valid & req_ready
//   req_address  byte address; the line index is req_address[IADDRW-1:4]
//   req_wr_en    1 = write, 0 = read
//   req_wr_data  write data; byte 0 lands at line offset req_address[3:0]
//   req_wr_size  number of bytes to write
//   resp_valid   a read line is available
//   resp_ready   consumer accepts the line
//   resp_data    aligned 16-byte line
//   mem_en       SRAM access this cycle
//   mem_we       SRAM write
//   mem_addr     SRAM line index
//   mem_wdata    SRAM write data, already rotated to its line position
//   mem_bmask    SRAM byte enables
//   mem_rdata    SRAM read data, valid MEM_LAT cycles after a read
// ---------------------------------------------------------------------------
module imem_ctrl #(
  parameter int IADDRW     = 32,
  parameter int IDATAW     = 128,
  parameter int ISIZEW     = 8,
  parameter int MEM_LAT    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [IADDRW-1:0] req_address,
  input  logic              req_wr_en,
  input  logic [IDATAW-1:0] req_wr_data,
  input  logic [ISIZEW-1:0] req_wr_size,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [IDATAW-1:0] resp_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [IADDRW-5:0] mem_addr,
  output logic [IDATAW-1:0] mem_wdata,
  output logic [15:0]       mem_bmask,
  input  logic [IDATAW-1:0] mem_rdata
);

  localparam int PTRW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNTW = $clog2(FIFO_DEPTH + 1);
  localparam int OUTW = $clog2(FIFO_DEPTH + MEM_LAT + 1);

  // -------------------------------------------------------------------------
  // Request acceptance and SRAM issue
  // -------------------------------------------------------------------------
  logic              accept;
  logic              wr_accept;
  logic              rd_accept;
  logic [3:0]        wr_off;
  logic [ISIZEW:0]   wr_end;     // one bit wider so off + size cannot wrap
  logic [15:0]       wr_bmask;
  logic [OUTW-1:0]   inflight;
  logic [OUTW-1:0]   outstanding;

  logic [MEM_LAT-1:0] pipe_valid_q, pipe_valid_d;
  logic [MEM_LAT-1:0] pipe_kill_q,  pipe_kill_d;

  logic [IDATAW-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [IDATAW-1:0] fifo_mem_d [FIFO_DEPTH];
  logic [PTRW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]   fifo_count_q, fifo_count_d;

  // Count every valid pipe entry, including killed ones. A killed entry
  // never pushes, so this is conservative. It also keeps the count simple.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < MEM_LAT; i++) begin
      inflight = inflight + OUTW'(pipe_valid_q[i]);
    end
    outstanding = inflight + OUTW'(fifo_count_q);
  end

  // The credit is taken from registered state only. A pop in this cycle
  // frees its slot starting next cycle.
  assign req_ready = reset & ~flush & (outstanding < OUTW'(FIFO_DEPTH));
  assign accept    = req_valid & req_ready;
  assign wr_accept = accept & req_wr_en;
  assign rd_accept = accept & ~req_wr_en;

  assign wr_off = req_address[3:0];
  assign wr_end = {{(ISIZEW - 3){1'b0}}, wr_off} + {1'b0, req_wr_size};

  // Byte b is written when off <= b < off + size. Bytes past 15 simply
  // fall off the end of the line; nothing wraps into the next line.
  for (genvar gi = 0; gi < 16; gi++) begin : g_bmask
    assign wr_bmask[gi] = (4'(gi) >= wr_off) && ((ISIZEW + 1)'(gi) < wr_end);
  end

  assign mem_en    = accept;
  assign mem_we    = wr_accept;
  assign mem_addr  = req_address[IADDRW-1:4];
  assign mem_wdata = req_wr_data << {wr_off, 3'b000};
  assign mem_bmask = wr_accept ? wr_bmask : 16'h0000;

  // -------------------------------------------------------------------------
  // In-flight pipe: one {valid, kill} pair per cycle of SRAM latency
  // -------------------------------------------------------------------------
  logic pipe_out_valid;
  logic pipe_out_kill;
  logic push;
  logic pop;

  always_comb begin
    pipe_valid_d    = '0;
    pipe_kill_d     = '0;
    pipe_valid_d[0] = rd_accept;
    for (int i = 1; i < MEM_LAT; i++) begin
      pipe_valid_d[i] = pipe_valid_q[i-1];
      pipe_kill_d[i]  = pipe_kill_q[i-1] | flush;
    end
  end

  // The last stage lines up with mem_rdata. A flush in this very cycle
  // also drops the returning line.
  assign pipe_out_valid = pipe_valid_q[MEM_LAT-1];
  assign pipe_out_kill  = pipe_kill_q[MEM_LAT-1] | flush;
  assign push           = pipe_out_valid & ~pipe_out_kill;

  // -------------------------------------------------------------------------
  // Response FIFO
  // -------------------------------------------------------------------------
  function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
    return (p == PTRW'(FIFO_DEPTH - 1)) ? '0 : p + PTRW'(1);
  endfunction

  assign resp_valid = reset & (fifo_count_q != '0);
  assign resp_data  = fifo_mem_q[rd_ptr_q];
  assign pop        = resp_valid & resp_ready;

  always_comb begin
    fifo_mem_d   = fifo_mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fifo_count_d = fifo_count_q;
    if (flush) begin
      // Flush wins over a pop in the same cycle; the FIFO ends empty.
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      fifo_count_d = '0;
    end else begin
      if (push) begin
        fifo_mem_d[wr_ptr_q] = mem_rdata;
        wr_ptr_d             = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({push, pop})
        2'b10:   fifo_count_d = fifo_count_q + CNTW'(1);
        2'b01:   fifo_count_d = fifo_count_q - CNTW'(1);
        default: fifo_count_d = fifo_count_q;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      pipe_valid_q <= '0;
      pipe_kill_q  <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
    end else begin
      pipe_valid_q <= pipe_valid_d;
      pipe_kill_q  <= pipe_kill_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_count_q <= fifo_count_d;
    end
  end

  // Line storage needs no reset; the empty count hides stale contents.
  always_ff @(posedge clk) begin
    fifo_mem_q <= fifo_mem_d;
  end

endmodule

// File: doc/imem_ctrl.md
Name: imem_ctrl

Overview:
- Instruction memory controller directly upstream of the fetch stage; serves its imem request/response interface.
- Accepts line read requests and byte-masked writes.
- Drives a synchronous SRAM port with fixed read latency.
- Returns 16-byte lines in request order through a credit-protected response FIFO. Flush discards all in-flight and buffered read data.

Parameters:
IADDRW, 32, request byte-address width
IDATAW, 128, line width in bits (16 bytes)
ISIZEW, 8, write size field width (bytes)
MEM_LAT, 2, SRAM read latency in cycles (1..4)
FIFO_DEPTH, 4, response FIFO entries; also the maximum outstanding reads

Ports:
clk  in  1  clock
reset  in  1  synchronous reset, active-low
flush  in  1  discard all outstanding and buffered reads
req_valid  in  1  request valid
req_ready  out  1  request accepted when valid&ready
req_address  in  IADDRW  byte address; line = req_address[IADDRW-1:4]
req_wr_en  in  1  1=write, 0=read
req_wr_data  in  IDATAW  write data, byte 0 at line offset req_address[3:0]
req_wr_size  in  ISIZEW  number of bytes to write
resp_valid  out  1  read line available
resp_ready  in  1  consumer accepts line
resp_data  out  IDATAW  aligned 16-byte line
mem_en  out  1  SRAM access this cycle
mem_we  out  1  SRAM write
mem_addr  out  IADDRW-4  SRAM line index
mem_wdata  out  IDATAW  SRAM write data, already rotated to line position
mem_bmask  out  16  SRAM byte enables
mem_rdata  in  IDATAW  SRAM read data, valid MEM_LAT cycles after a read

Behaviour:
Reset (reset==0 at a clock edge):
- Clears the FIFO, the in-flight pipe, and the kill bits.
- Outputs during reset: req_ready=0, resp_valid=0, mem_en=0, mem_we=0, mem_bmask=0.
- resp_data is don't-care.
- Reset mid-operation drops every in-flight read. No response from before reset ever appears.

Credit and acceptance:
- outstanding = in-flight reads + FIFO occupancy.
- req_ready = reset & ~flush & (outstanding < FIFO_DEPTH).
- Writes use the same req_ready. They take no credit, but are still blocked when credits are exhausted, so order is kept simple.
- A pop in the same cycle does not free a credit until the next cycle.

Issue (combinational from the accepted request):
- mem_en = req_valid & req_ready.
- mem_we = req_wr_en.
- mem_addr = req_address[IADDRW-1:4].
- Address bits [3:0] are ignored for reads; the full aligned line is returned.

Write byte mask and data:
- Byte b of the line is enabled iff off <= b < off + req_wr_size, with off = req_address[3:0].
- Bytes past 15 are truncated; there is no wrap into the next line.
- req_wr_size = 0 gives mem_bmask = 0, but mem_en is still asserted.
- mem_wdata = req_wr_data shifted left by 8*off bits.

In-flight pipe:
- MEM_LAT-stage shift register of {valid, kill}.
- An accepted read enters with valid=1, kill=0.
- When a valid entry exits the pipe, mem_rdata is pushed into the FIFO unless kill=1.

FIFO and response:
- Registered FIFO; resp_valid = FIFO non-empty; resp_data = head entry.
- Latency from read accept to resp_valid is MEM_LAT+1 cycles.
- While resp_valid & ~resp_ready, resp_valid and resp_data hold stable.
- Push and pop in the same cycle are legal. The credit rule guarantees no overflow.

Flush (level, single-cycle semantics):
- The FIFO is emptied at the edge, so resp_valid=0 next cycle.
- All in-flight entries get kill=1.
- req_ready=0 during the flush cycle.
- A write already issued to the SRAM completes normally.
- A pop and a flush in the same cycle: the flush wins and the FIFO ends empty.
- A read returning from the SRAM in the flush cycle is dropped.

Ordering:
- A read issued the cycle after a write to the same line returns the written bytes; the SRAM is write-first by order of issue.
- Responses are always delivered in request order.

Test Plan:
- Reset then read at address 0x0000_0013, SRAM line 1 = 0x00112233_..._FF -> mem_addr=1 in the accept cycle; resp_valid at accept+3 (MEM_LAT=2); resp_data = line 1; bits [3:0] ignored.
- 6 back-to-back reads with resp_ready=0 -> exactly 4 accepted, req_ready=0 after the 4th; raise resp_ready -> 4 lines in order, then the remaining 2 accepted, with req_ready returning 1 cycle after the first pop.
- Write at address 0x0000_002E, size 4, data 0xDDCCBBAA -> mem_bmask=0xC000 (bytes 14,15 only); mem_wdata bytes 14/15 = 0xAA/0xBB; then reading line 2 returns those bytes.
- Issue 2 reads, assert flush 1 cycle after the second accept -> neither response appears, resp_valid stays 0; a read after flush returns normally at +3.
- Flush while the FIFO holds 3 entries and resp_ready=1 -> FIFO empty next cycle; no extra pop is observed after the flush cycle.
- Reset pulse (reset=0, 1 cycle) with 2 reads in flight -> outputs zero during reset; no stale response afterwards; req_ready=1 the cycle after reset deasserts.
